// File: rtl/imm_rot_encoder.sv
// imm_rot_encoder: finds the canonical {rotate, imm8} operand2 encoding
// of a 32-bit constant, checking LANES rotations per search cycle.
module imm_rot_encoder #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        found,
    output logic [3:0]  rotate,
    output logic [7:0]  imm8,
    output logic [11:0] shift_operand
);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 ||
              LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("imm_rot_encoder: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] val_q, val_d;
    logic [3:0]  r_q, r_d;
    logic        found_q, found_d;
    logic [3:0]  rot_q, rot_d;
    logic [7:0]  imm_q, imm_d;

    logic        hit_any;
    logic [3:0]  hit_k;
    logic [7:0]  hit_imm;
    logic        last_pass;
    logic [3:0]  lane_k;
    logic [4:0]  lane_sh;
    logic [31:0] lane_cand;

    // Evaluate this cycle's lanes; scanning high to low leaves the smallest hit.
    always_comb begin
        hit_any   = 1'b0;
        hit_k     = 4'd0;
        hit_imm   = 8'd0;
        lane_k    = 4'd0;
        lane_sh   = 5'd0;
        lane_cand = 32'd0;
        for (int j = LANES - 1; j >= 0; j--) begin
            lane_k    = r_q + 4'(j);
            lane_sh   = {lane_k, 1'b0};
            lane_cand = (val_q << lane_sh) |
                        (val_q >> (6'd32 - {1'b0, lane_sh}));
            if (lane_cand[31:8] == 24'd0) begin
                hit_any = 1'b1;
                hit_k   = lane_k;
                hit_imm = lane_cand[7:0];
            end
        end
    end

    assign last_pass = ({1'b0, r_q} + 5'(LANES)) == 5'd16;

    // Next-state and next-datapath logic for the search FSM.
    always_comb begin
        state_d = state_q;
        val_d   = val_q;
        r_d     = r_q;
        found_d = found_q;
        rot_d   = rot_q;
        imm_d   = imm_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    val_d   = value;
                    r_d     = 4'd0;
                    state_d = SEARCH;
                end
            end
            SEARCH: begin
                if (hit_any) begin
                    found_d = 1'b1;
                    rot_d   = hit_k;
                    imm_d   = hit_imm;
                    state_d = DONE;
                end else if (last_pass) begin
                    found_d = 1'b0;
                    rot_d   = 4'd0;
                    imm_d   = 8'd0;
                    state_d = DONE;
                end else begin
                    r_d = r_q + 4'(LANES);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            val_q   <= 32'd0;
            r_q     <= 4'd0;
            found_q <= 1'b0;
            rot_q   <= 4'd0;
            imm_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            val_q   <= val_d;
            r_q     <= r_d;
            found_q <= found_d;
            rot_q   <= rot_d;
            imm_q   <= imm_d;
        end
    end

    assign in_ready      = (state_q == IDLE);
    assign out_valid     = (state_q == DONE);
    assign found         = found_q;
    assign rotate        = rot_q;
    assign imm8          = imm_q;
    assign shift_operand = found_q ? {rot_q, imm_q} : 12'h000;

endmodule

// File: tb/tb_imm_rot_encoder.sv
// tb_imm_rot_encoder: vector table, corner sequences and randomized
// round-trip checks for a LANES=1 and a LANES=4 encoder.
module tb_imm_rot_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        iv  [2];
    logic        ir  [2];
    logic        ov  [2];
    logic        orr [2];
    logic        fd  [2];
    logic [31:0] val [2];
    logic [3:0]  rot [2];
    logic [7:0]  imm [2];
    logic [11:0] so  [2];

    int total = 0;
    int bad   = 0;

    imm_rot_encoder #(.LANES(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[0]), .in_ready(ir[0]), .value(val[0]),
        .out_valid(ov[0]), .out_ready(orr[0]),
        .found(fd[0]), .rotate(rot[0]), .imm8(imm[0]),
        .shift_operand(so[0])
    );

    imm_rot_encoder #(.LANES(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(iv[1]), .in_ready(ir[1]), .value(val[1]),
        .out_valid(ov[1]), .out_ready(orr[1]),
        .found(fd[1]), .rotate(rot[1]), .imm8(imm[1]),
        .shift_operand(so[1])
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotl(input logic [31:0] x, input int s);
        logic [63:0] t;
        t = {x, x} << s;
        return t[63:32];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
        logic [63:0] t;
        t = {x, x} >> s;
        return t[31:0];
    endfunction

    // Reference: try every rotate, keep the smallest whose decode reproduces v.
    function automatic void ref_enc(input logic [31:0] v, output logic f,
                                    output logic [3:0] r, output logic [7:0] i);
        logic [31:0] c;
        f = 1'b0; r = 4'd0; i = 8'd0;
        for (int k = 15; k >= 0; k--) begin
            c = rotl(v, 2 * k);
            if (rotr({24'd0, c[7:0]}, 2 * k) == v) begin
                f = 1'b1; r = 4'(k); i = c[7:0];
            end
        end
    endfunction

    task automatic run(input int d, input logic [31:0] v, input int hold,
                       output logic f, output logic [3:0] r,
                       output logic [7:0] i, output logic [11:0] s,
                       output int lat);
        int n;
        n = 0;
        while (!ir[d] && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("accept_ready", ir[d], 1);
        iv[d] = 1'b1; val[d] = v;
        @(posedge clk); #1;
        iv[d] = 1'b0; val[d] = $urandom;
        lat = 0;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ov[d] && lat < 40);
        chk("out_valid", ov[d], 1);
        chk("done_in_ready", ir[d], 0);
        f = fd[d]; r = rot[d]; i = imm[d]; s = so[d];
        repeat (hold) begin
            @(posedge clk); #1;
            chk("hold_valid", ov[d], 1);
            chk("hold_rot", rot[d], r);
            chk("hold_imm", imm[d], i);
            chk("hold_in_ready", ir[d], 0);
        end
        orr[d] = 1'b1;
        @(posedge clk); #1;
        orr[d] = 1'b0;
        chk("post_hs_in_ready", ir[d], 1);
        chk("post_hs_out_valid", ov[d], 0);
    endtask

    typedef struct {
        int          d;
        logic [31:0] v;
        logic        f;
        logic [3:0]  r;
        logic [7:0]  i;
        logic [11:0] s;
        int          lat;
    } vec_t;

    vec_t vt[10];

    initial begin
        logic        f, ef;
        logic [3:0]  r, er;
        logic [7:0]  i, ei;
        logic [11:0] s;
        int          lat, elat, d;
        logic [31:0] v;

        vt[0] = '{0, 32'h0000_00FF, 1'b1, 4'd0,  8'hFF, 12'h0FF, 1};
        vt[1] = '{0, 32'hF000_000F, 1'b1, 4'd2,  8'hFF, 12'h2FF, 3};
        vt[2] = '{0, 32'h0000_0104, 1'b1, 4'd15, 8'h41, 12'hF41, 16};
        vt[3] = '{0, 32'h0000_0101, 1'b0, 4'd0,  8'h00, 12'h000, 16};
        vt[4] = '{1, 32'h0000_0101, 1'b0, 4'd0,  8'h00, 12'h000, 4};
        vt[5] = '{1, 32'h0000_0104, 1'b1, 4'd15, 8'h41, 12'hF41, 4};
        vt[6] = '{1, 32'hF000_000F, 1'b1, 4'd2,  8'hFF, 12'h2FF, 1};
        vt[7] = '{0, 32'h0000_0000, 1'b1, 4'd0,  8'h00, 12'h000, 1};
        vt[8] = '{1, 32'hFF00_0000, 1'b1, 4'd4,  8'hFF, 12'h4FF, 2};
        vt[9] = '{0, 32'hFFFF_FFFF, 1'b0, 4'd0,  8'h00, 12'h000, 16};

        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; orr[k] = 1'b0; val[k] = 32'd0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_in_ready", ir[k], 1);
            chk("rst_out_valid", ov[k], 0);
            chk("rst_found", fd[k], 0);
            chk("rst_so", so[k], 0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        foreach (vt[n]) begin
            run(vt[n].d, vt[n].v, 0, f, r, i, s, lat);
            chk($sformatf("vec%0d_found", n), f, vt[n].f);
            chk($sformatf("vec%0d_rot", n), r, vt[n].r);
            chk($sformatf("vec%0d_imm", n), i, vt[n].i);
            chk($sformatf("vec%0d_so", n), s, vt[n].s);
            chk($sformatf("vec%0d_lat", n), lat, vt[n].lat);
        end

        run(0, 32'hFF00_0000, 5, f, r, i, s, lat);
        chk("bp_rot", r, 4);
        chk("bp_imm", i, 8'hFF);
        chk("bp_lat", lat, 5);

        iv[0] = 1'b1; val[0] = 32'h0000_0104;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", ir[0], 1);
        chk("mid_rst_out_valid", ov[0], 0);
        chk("mid_rst_found", fd[0], 0);
        chk("mid_rst_so", so[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            chk("no_stale_valid", ov[0], 0);
        end

        for (int n = 0; n < 2400; n++) begin
            d = (n < 400) ? 0 : 1;
            if ($urandom_range(1) == 1)
                v = rotr({24'd0, 8'($urandom_range(255))},
                         2 * $urandom_range(15));
            else
                v = $urandom;
            ref_enc(v, ef, er, ei);
            if (ef) elat = int'(er) / (d == 0 ? 1 : 4) + 1;
            else    elat = (d == 0) ? 16 : 4;
            run(d, v, 0, f, r, i, s, lat);
            chk("rnd_found", f, ef);
            chk("rnd_rot", r, er);
            chk("rnd_imm", i, ei);
            chk("rnd_so", s, ef ? {er, ei} : 12'h000);
            chk("rnd_lat", lat, elat);
            if (f) chk("rnd_roundtrip", rotr({24'd0, i}, 2 * int'(r)), v);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
